// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between the core
// and a debug/loader master, with a bounded debug lock and read-data steering.
//
// state     | meaning
// ----------+------------------------------------------------------------------
// ST_IDLE   | round-robin between core and debug; last_dbg breaks ties
// ST_LOCKED | debug owns the port while dbg_lock=1, up to LOCK_MAX grants in a row
module dmem_port_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rstn,

  input  logic        core_req,
  input  logic [3:0]  core_we,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [2:0]  core_load_select,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,

  input  logic        dbg_req,
  input  logic [3:0]  dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic [2:0]  dbg_load_select,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,

  output logic        mem_rd,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_load_select,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_MAX);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             last_dbg_q, last_dbg_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             rd_pend_q;
  logic             rd_owner_q;

  logic             lock_hold;
  logic             core_win;
  logic             dbg_win;
  logic             any_win;
  logic [3:0]       sel_we;
  logic [CNT_W-1:0] cnt_inc;

  // Dropping dbg_lock releases the port in the same cycle, so the lock only
  // dominates arbitration while it is still asserted.
  always_comb begin
    lock_hold = (state_q == ST_LOCKED) && dbg_lock;
    core_win  = 1'b0;
    dbg_win   = 1'b0;
    if (lock_hold) begin
      dbg_win = dbg_req;
    end else if (core_req && dbg_req) begin
      core_win = last_dbg_q;
      dbg_win  = !last_dbg_q;
    end else begin
      core_win = core_req;
      dbg_win  = dbg_req;
    end
  end

  assign any_win  = core_win || dbg_win;
  assign core_gnt = core_win;
  assign dbg_gnt  = dbg_win;

  // With no winner the core fields sit on the address/data bus as don't-cares.
  assign sel_we          = dbg_win ? dbg_we          : core_we;
  assign mem_addr        = dbg_win ? dbg_addr        : core_addr;
  assign mem_wdata       = dbg_win ? dbg_wdata       : core_wdata;
  assign mem_load_select = dbg_win ? dbg_load_select : core_load_select;
  assign mem_we          = any_win ? sel_we : 4'b0000;
  assign mem_rd          = any_win && (sel_we == 4'b0000);

  assign cnt_inc = lock_cnt_q + CNT_ONE;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    last_dbg_d = last_dbg_q;

    if (any_win) begin
      last_dbg_d = dbg_win;
    end

    case (state_q)
      ST_IDLE: begin
        // A single-grant lock is already exhausted, so it never leaves IDLE.
        if (dbg_win && dbg_lock && (LOCK_MAX > 1)) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = CNT_ONE;
        end
      end
      ST_LOCKED: begin
        if (!dbg_lock) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else if (dbg_win) begin
          if (cnt_inc == CNT_LIMIT) begin
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = cnt_inc;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      last_dbg_q <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_dbg_q <= last_dbg_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Memory returns read data one cycle after the read edge; remember whose it is.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q <= mem_rd;
      if (mem_rd) begin
        rd_owner_q <= dbg_win;
      end
    end
  end

  assign core_rvalid = rd_pend_q && !rd_owner_q;
  assign dbg_rvalid  = rd_pend_q && rd_owner_q;
  assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rdata : 32'h0;

endmodule
